// File: rtl/dct_block_arbiter.sv
// dct_block_arbiter
// Shares one DCT_0 HLS core between two 32-bit host stream channels.
// The core is granted to one channel for a whole block of BLOCK_WORDS input
// words and BLOCK_WORDS output words. Input words go to the core's X port and
// the core's Y words go back to that channel's output FIFO. Ownership is
// re-arbitrated round-robin only at block boundaries. If the owning channel
// closes mid-block, the core is held in reset for two cycles and the partial
// block is dropped.
//
// Optional build macro: DCT_ARB_STATS_EN adds the blk_cnt0, blk_cnt1 and
// abort_cnt statistics outputs.
module dct_block_arbiter #(
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 64,
  parameter int CNT_W       = 7
) (
  input  logic              bus_clk,
  input  logic              ap_rst,
  input  logic              ch0_open,
  input  logic              ch1_open,
  // channel 0 FIFOs
  input  logic [DATA_W-1:0] ch0_in_dout,
  input  logic              ch0_in_empty,
  output logic              ch0_in_rd_en,
  output logic [DATA_W-1:0] ch0_out_din,
  output logic              ch0_out_wr_en,
  input  logic              ch0_out_full,
  // channel 1 FIFOs
  input  logic [DATA_W-1:0] ch1_in_dout,
  input  logic              ch1_in_empty,
  output logic              ch1_in_rd_en,
  output logic [DATA_W-1:0] ch1_out_din,
  output logic              ch1_out_wr_en,
  input  logic              ch1_out_full,
  // core streams
  output logic [DATA_W-1:0] X_dout,
  output logic              X_empty_n,
  input  logic              X_read,
  input  logic [DATA_W-1:0] Y_din,
  output logic              Y_full_n,
  input  logic              Y_write,
  // control / status
  output logic              core_rst,
  output logic              grant,
  output logic              busy
`ifdef DCT_ARB_STATS_EN
  ,
  output logic [31:0]       blk_cnt0,
  output logic [31:0]       blk_cnt1,
  output logic [15:0]       abort_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] BLK_END = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             rr_next;
  logic             abort_ph;

  logic              req0;
  logic              req1;
  logic              sel_open;
  logic              sel_empty;
  logic              sel_full;
  logic [DATA_W-1:0] sel_dout;
  logic              x_take;
  logic              y_take;
  logic              block_done;

  // Per-channel requests and the views of the granted channel's FIFOs
  always_comb begin
    req0       = ch0_open & ~ch0_in_empty;
    req1       = ch1_open & ~ch1_in_empty;
    sel_open   = grant ? ch1_open     : ch0_open;
    sel_empty  = grant ? ch1_in_empty : ch0_in_empty;
    sel_full   = grant ? ch1_out_full : ch0_out_full;
    sel_dout   = grant ? ch1_in_dout  : ch0_in_dout;
    block_done = (in_cnt == BLK_END) && (out_cnt == BLK_END);
  end

  // Core-side handshakes: only live in BUSY and gated by the block word budget
  always_comb begin
    X_dout    = sel_dout;
    X_empty_n = 1'b0;
    Y_full_n  = 1'b0;
    if (state == S_BUSY) begin
      X_empty_n = ~sel_empty & (in_cnt < BLK_END);
      Y_full_n  = ~sel_full & (out_cnt < BLK_END);
    end
    x_take = X_read & X_empty_n;
    y_take = Y_write & Y_full_n;
  end

  // FIFO strobes steered to the granted channel only
  always_comb begin
    ch0_in_rd_en  = x_take & ~grant;
    ch1_in_rd_en  = x_take & grant;
    ch0_out_wr_en = y_take & ~grant;
    ch1_out_wr_en = y_take & grant;
    ch0_out_din   = Y_din;
    ch1_out_din   = Y_din;
  end

  // Status outputs; the core is also reset for the two ABORT cycles
  always_comb begin
    busy     = (state == S_BUSY);
    core_rst = ap_rst | (state == S_ABORT);
  end

  // Block FSM: grant, per-block word counters, round-robin pointer
  always_ff @(posedge bus_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= S_IDLE;
      in_cnt   <= '0;
      out_cnt  <= '0;
      grant    <= 1'b0;
      rr_next  <= 1'b0;
      abort_ph <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            grant   <= (req0 & req1) ? rr_next : req1;
            in_cnt  <= '0;
            out_cnt <= '0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!sel_open) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            abort_ph <= 1'b0;
            state    <= S_ABORT;
          end else if (block_done) begin
            state <= S_DONE;
          end else begin
            if (x_take) in_cnt  <= in_cnt + CNT_ONE;
            if (y_take) out_cnt <= out_cnt + CNT_ONE;
          end
        end
        S_DONE: begin
          rr_next <= ~grant;
          state   <= S_IDLE;
        end
        S_ABORT: begin
          rr_next  <= ~grant;
          in_cnt   <= '0;
          out_cnt  <= '0;
          abort_ph <= 1'b1;
          if (abort_ph) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DCT_ARB_STATS_EN
  // Completed-block and abort statistics, free-running with wrap
  always_ff @(posedge bus_clk or posedge ap_rst) begin
    if (ap_rst) begin
      blk_cnt0  <= '0;
      blk_cnt1  <= '0;
      abort_cnt <= '0;
    end else begin
      if (state == S_DONE) begin
        if (grant) blk_cnt1 <= blk_cnt1 + 32'd1;
        else       blk_cnt0 <= blk_cnt0 + 32'd1;
      end
      if ((state == S_BUSY) && !sel_open) abort_cnt <= abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dct_block_arbiter.sv
// tb_dct_block_arbiter
// Bench for dct_block_arbiter: FIFO and echo-core models around the DUT,
// a stimulus process that queues expected grants/words, and a monitor that
// pops and compares whenever the DUT presents a transfer.
// Build with DCT_ARB_STATS_EN defined to also check the statistics outputs.
module tb_dct_block_arbiter;

  localparam int DW = 32;
  localparam int BW = 64;

  logic          bus_clk = 1'b0;
  logic          ap_rst  = 1'b1;
  logic          ch0_open = 1'b0, ch1_open = 1'b0;
  logic [DW-1:0] ch0_in_dout = '0, ch1_in_dout = '0;
  logic          ch0_in_empty = 1'b1, ch1_in_empty = 1'b1;
  logic          ch0_in_rd_en, ch1_in_rd_en;
  logic [DW-1:0] ch0_out_din, ch1_out_din;
  logic          ch0_out_wr_en, ch1_out_wr_en;
  logic          ch0_out_full = 1'b0, ch1_out_full = 1'b0;
  logic [DW-1:0] X_dout;
  logic          X_empty_n;
  logic          X_read = 1'b0;
  logic [DW-1:0] Y_din = '0;
  logic          Y_full_n;
  logic          Y_write = 1'b0;
  logic          core_rst, grant, busy;
`ifdef DCT_ARB_STATS_EN
  logic [31:0]   blk_cnt0, blk_cnt1;
  logic [15:0]   abort_cnt;
`endif

  dct_block_arbiter #(.DATA_W(DW), .BLOCK_WORDS(BW), .CNT_W(7)) dut (
    .bus_clk(bus_clk), .ap_rst(ap_rst),
    .ch0_open(ch0_open), .ch1_open(ch1_open),
    .ch0_in_dout(ch0_in_dout), .ch0_in_empty(ch0_in_empty), .ch0_in_rd_en(ch0_in_rd_en),
    .ch0_out_din(ch0_out_din), .ch0_out_wr_en(ch0_out_wr_en), .ch0_out_full(ch0_out_full),
    .ch1_in_dout(ch1_in_dout), .ch1_in_empty(ch1_in_empty), .ch1_in_rd_en(ch1_in_rd_en),
    .ch1_out_din(ch1_out_din), .ch1_out_wr_en(ch1_out_wr_en), .ch1_out_full(ch1_out_full),
    .X_dout(X_dout), .X_empty_n(X_empty_n), .X_read(X_read),
    .Y_din(Y_din), .Y_full_n(Y_full_n), .Y_write(Y_write),
    .core_rst(core_rst), .grant(grant), .busy(busy)
`ifdef DCT_ARB_STATS_EN
    , .blk_cnt0(blk_cnt0), .blk_cnt1(blk_cnt1), .abort_cnt(abort_cnt)
`endif
  );

  always #5 bus_clk = ~bus_clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] inq0[$], inq1[$], cq[$];
  logic [DW-1:0] exp0[$], exp1[$], expx[$];
  int            expg[$];

  int pops0 = 0, pops1 = 0, wr1_cnt = 0, cyc = 0, last_wr_cyc = 0, bp_samples = 0;
  bit ch1_quiet = 0, bp_active = 0, gap_en = 1, abort_chk = 0, force_full1 = 0;
  int rr_model = 0, blk_m0 = 0, blk_m1 = 0, abort_m = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic update_pins();
    ch0_in_empty = (inq0.size() == 0);
    ch1_in_empty = (inq1.size() == 0);
    ch0_in_dout  = ch0_in_empty ? '0 : inq0[0];
    ch1_in_dout  = ch1_in_empty ? '0 : inq1[0];
  endtask

  // FIFO + echo core model: drive at negedge, capture handshakes, apply after posedge
  initial begin
    bit xf, yf, crst, r0, r1;
    logic [DW-1:0] xd;
    forever begin
      @(negedge bus_clk);
      update_pins();
      X_read  = ($urandom_range(0, 3) != 0);
      Y_write = (cq.size() > 0) && ($urandom_range(0, 4) != 0);
      if (cq.size() > 0) Y_din = cq[0];
      ch0_out_full = ($urandom_range(0, 7) == 0);
      ch1_out_full = force_full1 || ($urandom_range(0, 7) == 0);
      #1;
      xf = X_read && X_empty_n;
      yf = Y_write && Y_full_n;
      xd = X_dout;
      crst = core_rst;
      r0 = ch0_in_rd_en;
      r1 = ch1_in_rd_en;
      @(posedge bus_clk);
      #1;
      if (crst) cq.delete();
      else begin
        if (yf && cq.size() > 0) void'(cq.pop_front());
        if (xf) cq.push_back(xd + 32'd1);
      end
      if (r0 && inq0.size() > 0) begin void'(inq0.pop_front()); pops0++; end
      if (r1 && inq1.size() > 0) begin void'(inq1.pop_front()); pops1++; end
      update_pins();
    end
  end

  // Monitor / scoreboard
  initial begin
    bit pbusy = 0;
    int crun = 0;
    forever begin
      @(negedge bus_clk);
      #2;
      cyc++;
      if (X_read && X_empty_n) begin
        check("x_word_expected", expx.size() > 0, 1);
        if (expx.size() > 0) check("x_data", X_dout, expx.pop_front());
      end
      if (ch0_out_wr_en) begin
        check("ch0_wr_while_full", ch0_out_full, 0);
        check("ch0_word_expected", exp0.size() > 0, 1);
        if (exp0.size() > 0) check("ch0_out_data", ch0_out_din, exp0.pop_front());
        last_wr_cyc = cyc;
      end
      if (ch1_out_wr_en) begin
        check("ch1_wr_while_full", ch1_out_full, 0);
        check("ch1_word_expected", exp1.size() > 0, 1);
        if (exp1.size() > 0) check("ch1_out_data", ch1_out_din, exp1.pop_front());
        last_wr_cyc = cyc;
        wr1_cnt++;
      end
      if (ch1_quiet) begin
        check("ch1_rd_quiet", ch1_in_rd_en, 0);
        check("ch1_wr_quiet", ch1_out_wr_en, 0);
      end
      if (bp_active) begin
        check("bp_y_full_n", Y_full_n, 0);
        bp_samples++;
      end
      if (busy && !pbusy) begin
        check("grant_expected", expg.size() > 0, 1);
        if (expg.size() > 0) check("grant_order", grant, expg.pop_front());
      end
      if (!busy && pbusy && gap_en) check("done_gap", cyc - last_wr_cyc, 2);
      if (core_rst) crun++;
      else begin
        if (crun > 0 && abort_chk) begin
          check("abort_rst_len", crun, 2);
          check("abort_to_idle_busy", busy, 0);
          abort_chk = 0;
        end
        crun = 0;
      end
      pbusy = busy;
    end
  end

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge bus_clk);
      #3;
      if (exp0.size() == 0 && exp1.size() == 0 && expx.size() == 0 &&
          expg.size() == 0 && !busy) done = 1;
    end
    check({name, "_drained"}, done, 1);
    repeat (3) @(posedge bus_clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_grant"}, grant, 0);
    check({name, "_core_rst"}, core_rst, 1);
    check({name, "_x_empty_n"}, X_empty_n, 0);
    check({name, "_y_full_n"}, Y_full_n, 0);
    check({name, "_strobes"}, {ch0_in_rd_en, ch1_in_rd_en, ch0_out_wr_en, ch1_out_wr_en}, 0);
  endtask

  // Queue one block of words for a channel with its expected outputs
  task automatic queue_block(input int ch, input bit seq, input int base, input bit to_x);
    logic [DW-1:0] w;
    for (int i = 0; i < BW; i++) begin
      w = seq ? DW'(base + i) : DW'($urandom);
      if (ch == 0) begin inq0.push_back(w); exp0.push_back(w + 32'd1); end
      else         begin inq1.push_back(w); exp1.push_back(w + 32'd1); end
      if (to_x) expx.push_back(w);
    end
  endtask

  // Stimulus
  initial begin
    bit seen;
    int g;
    logic [DW-1:0] blkw[2][$];

    repeat (2) @(posedge bus_clk);
    #1;
    check_reset_outputs("reset");
    #2 ap_rst = 1'b0;

    // Single channel, words 0..63
    queue_block(0, 1, 0, 1);
    expg.push_back(rr_model); // rr pointer 0 -> ch0
    rr_model = 1; blk_m0++;
    ch1_quiet = 1;
    ch0_open  = 1;
    wait_drain("single");
    check("single_pops", pops0, BW);
    ch1_quiet = 0;
    ch0_open  = 0;

    // Async reset in the middle of a ch1 block
    queue_block(1, 0, 0, 1);
    expg.push_back(1);
    ch1_open = 1;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge bus_clk);
      #2;
      if (pops1 >= 10) seen = 1;
    end
    check("rst_block_started", seen, 1);
    gap_en = 0;
    #1 ap_rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    inq0.delete(); inq1.delete();
    exp0.delete(); exp1.delete(); expx.delete(); expg.delete();
    ch1_open = 0;
    rr_model = 0; blk_m0 = 0; blk_m1 = 0; abort_m = 0;
    repeat (2) @(posedge bus_clk);
    #3 ap_rst = 1'b0;
    repeat (2) @(posedge bus_clk);
    #2 gap_en = 1;

    // Contention: 128 words per channel, round-robin per block from the model
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 2 * BW; i++) blkw[c].push_back(DW'($urandom));
    for (int i = 0; i < 2 * BW; i++) begin
      inq0.push_back(blkw[0][i]); exp0.push_back(blkw[0][i] + 32'd1);
      inq1.push_back(blkw[1][i]); exp1.push_back(blkw[1][i] + 32'd1);
    end
    for (int b = 0; b < 4; b++) begin
      g = rr_model;
      expg.push_back(g);
      for (int i = 0; i < BW; i++) expx.push_back(blkw[g][(b / 2) * BW + i]);
      if (g == 0) blk_m0++; else blk_m1++;
      rr_model = 1 - g;
    end
    ch0_open = 1;
    ch1_open = 1;
    wait_drain("contention");
    ch0_open = 0;
    ch1_open = 0;

    // Backpressure on ch1 output for 20 cycles mid-block
    wr1_cnt = 0;
    queue_block(1, 0, 0, 1);
    expg.push_back(1);
    blk_m1++; rr_model = 0;
    ch1_open = 1;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge bus_clk);
      #1;
      if (wr1_cnt >= 20) seen = 1;
    end
    check("bp_reached_mid_block", seen, 1);
    bp_samples  = 0;
    force_full1 = 1;
    bp_active   = 1;
    repeat (20) @(posedge bus_clk);
    #1;
    force_full1 = 0;
    bp_active   = 0;
    check("bp_window_cycles", bp_samples, 20);
    wait_drain("backpressure");
    check("bp_block_words", wr1_cnt, BW);
    ch1_open = 0;

    // Abort: ch0 closes after 30 inputs, queued ch1 block follows
    pops0 = 0;
    queue_block(0, 0, 0, 1);
    queue_block(1, 0, 0, 0);
    expg.push_back(rr_model); // 0: both request, pointer at ch0
    expg.push_back(1);
    abort_m++; blk_m1++; rr_model = 0;
    gap_en    = 0;
    abort_chk = 1;
    ch0_open  = 1;
    ch1_open  = 1;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge bus_clk);
      #2;
      if (pops0 >= 30) seen = 1;
    end
    check("abort_inputs_reached", seen, 1);
    ch0_open = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge bus_clk);
      #3;
      if (core_rst) seen = 1;
    end
    check("abort_core_rst_seen", seen, 1);
    exp0.delete();
    expx.delete();
    inq0.delete();
    foreach (inq1[i]) expx.push_back(inq1[i]);
    gap_en = 1;
    wait_drain("abort");
    check("abort_check_ran", abort_chk, 0);
    ch1_open = 0;

`ifdef DCT_ARB_STATS_EN
    check("stat_blk_cnt0", blk_cnt0, blk_m0);
    check("stat_blk_cnt1", blk_cnt1, blk_m1);
    check("stat_abort_cnt", abort_cnt, abort_m);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
